// File: rtl/int_ctrl.sv
// Machine-mode trap controller for core0: arbitrates ECALL/EBREAK, external,
// software and timer interrupts, sequences the trap CSR writes and handles MRET.
module int_ctrl #(
    parameter int unsigned NUM_EXT_IRQ = 4,
    parameter bit          VECTORED_EN = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   timer_int_i,
    input  logic                   soft_int_i,
    input  logic [NUM_EXT_IRQ-1:0] ext_irq_i,
    input  logic [31:0]            id_inst_i,
    input  logic [31:0]            id_pc_i,
    input  logic                   id_jump_flag_i,
    input  logic [31:0]            id_jump_pc_i,
    input  logic                   ex_branch_flag_i,
    input  logic [31:0]            ex_branch_pc_i,
    input  logic [31:0]            mstatus_i,
    input  logic [31:0]            mie_i,
    input  logic [31:0]            mtvec_i,
    input  logic [31:0]            mepc_i,
    output logic [11:0]            cl_csr_waddr_o,
    output logic [31:0]            cl_csr_wdata_o,
    output logic                   cl_csr_we_o,
    output logic                   cl_int_o,
    output logic [31:0]            cl_addr_o,
    output logic                   cl_stall_o,
    output logic [NUM_EXT_IRQ-1:0] ext_claim_o,
    output logic [31:0]            mip_o
);

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MEPC,
        S_MCAUSE,
        S_MSTATUS,
        S_MRET
    } state_t;

    state_t                 state;
    logic [31:0]            cause_q;
    logic [31:0]            epc_q;
    logic [NUM_EXT_IRQ-1:0] claim_q;

    logic                   busy;
    logic                   is_sync;
    logic                   soft_en;
    logic                   timer_en;
    logic [NUM_EXT_IRQ-1:0] ext_en;
    logic [NUM_EXT_IRQ-1:0] ext_onehot;
    logic                   ext_hit;
    logic [3:0]             ext_idx;
    logic                   take_trap;
    logic                   take_asyn;
    logic                   take_ret;
    logic                   decision_valid;
    logic [31:0]            dec_cause;
    logic [31:0]            dec_epc;
    logic [31:0]            tvec_base;
    logic [31:0]            handler;
    logic [31:0]            trap_mstatus;
    logic [31:0]            ret_mstatus;
    logic                   unused_mie;

    assign unused_mie = ^mie_i;

    assign busy     = (state != S_IDLE) | cl_int_o;
    assign is_sync  = (id_inst_i == INST_ECALL) | (id_inst_i == INST_EBREAK);
    assign soft_en  = soft_int_i & mie_i[3];
    assign timer_en = timer_int_i & mie_i[7];

    // Lowest-numbered enabled external source wins.
    always_comb begin
        ext_en     = ext_irq_i & mie_i[16 +: NUM_EXT_IRQ];
        ext_hit    = 1'b0;
        ext_idx    = '0;
        ext_onehot = '0;
        for (int unsigned i = 0; i < NUM_EXT_IRQ; i++) begin
            if (ext_en[i] && !ext_hit) begin
                ext_hit       = 1'b1;
                ext_idx       = i[3:0];
                ext_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        take_trap = 1'b0;
        take_asyn = 1'b0;
        take_ret  = 1'b0;
        dec_cause = '0;
        dec_epc   = '0;
        if (!busy) begin
            if (is_sync && !ex_branch_flag_i) begin
                take_trap = 1'b1;
                dec_cause = (id_inst_i == INST_ECALL) ? 32'd11 : 32'd3;
                dec_epc   = id_pc_i;
            end else if (mstatus_i[3] && (ext_hit || soft_en || timer_en)) begin
                take_trap = 1'b1;
                take_asyn = 1'b1;
                if (ext_hit)
                    dec_cause = {1'b1, 26'd0, 1'b1, ext_idx};
                else if (soft_en)
                    dec_cause = 32'h8000_0003;
                else
                    dec_cause = 32'h8000_0007;
                if (ex_branch_flag_i)
                    dec_epc = ex_branch_pc_i;
                else if (id_jump_flag_i)
                    dec_epc = id_jump_pc_i;
                else
                    dec_epc = id_pc_i;
            end else if (id_inst_i == INST_MRET) begin
                take_ret = 1'b1;
            end
        end
    end

    assign decision_valid = take_trap | take_ret;
    assign cl_stall_o     = decision_valid | busy;

    assign tvec_base = {mtvec_i[31:2], 2'b00};
    assign handler   = (VECTORED_EN && (mtvec_i[1:0] == 2'b01) && cause_q[31])
                       ? tvec_base + {25'd0, cause_q[4:0], 2'b00}
                       : tvec_base;

    always_comb begin
        trap_mstatus        = mstatus_i;
        trap_mstatus[7]     = mstatus_i[3];
        trap_mstatus[3]     = 1'b0;
        trap_mstatus[12:11] = 2'b11;
        ret_mstatus         = mstatus_i;
        ret_mstatus[3]      = mstatus_i[7];
        ret_mstatus[7]      = 1'b1;
    end

    always_comb begin
        mip_o                    = '0;
        mip_o[3]                 = soft_int_i;
        mip_o[7]                 = timer_int_i;
        mip_o[16 +: NUM_EXT_IRQ] = ext_irq_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            cause_q        <= '0;
            epc_q          <= '0;
            claim_q        <= '0;
            cl_csr_we_o    <= 1'b0;
            cl_csr_waddr_o <= '0;
            cl_csr_wdata_o <= '0;
            cl_int_o       <= 1'b0;
            cl_addr_o      <= '0;
            ext_claim_o    <= '0;
        end else begin
            cl_csr_we_o    <= 1'b0;
            cl_csr_waddr_o <= '0;
            cl_csr_wdata_o <= '0;
            cl_int_o       <= 1'b0;
            cl_addr_o      <= '0;
            ext_claim_o    <= '0;
            case (state)
                S_IDLE: begin
                    if (take_trap) begin
                        state   <= S_MEPC;
                        cause_q <= dec_cause;
                        epc_q   <= dec_epc;
                        claim_q <= take_asyn ? ext_onehot : '0;
                    end else if (take_ret) begin
                        state <= S_MRET;
                    end
                end
                S_MEPC: begin
                    cl_csr_we_o    <= 1'b1;
                    cl_csr_waddr_o <= CSR_MEPC;
                    cl_csr_wdata_o <= epc_q;
                    state          <= S_MCAUSE;
                end
                S_MCAUSE: begin
                    cl_csr_we_o    <= 1'b1;
                    cl_csr_waddr_o <= CSR_MCAUSE;
                    cl_csr_wdata_o <= cause_q;
                    ext_claim_o    <= claim_q;
                    state          <= S_MSTATUS;
                end
                S_MSTATUS: begin
                    cl_csr_we_o    <= 1'b1;
                    cl_csr_waddr_o <= CSR_MSTATUS;
                    cl_csr_wdata_o <= trap_mstatus;
                    cl_int_o       <= 1'b1;
                    cl_addr_o      <= handler;
                    state          <= S_IDLE;
                end
                S_MRET: begin
                    cl_csr_we_o    <= 1'b1;
                    cl_csr_waddr_o <= CSR_MSTATUS;
                    cl_csr_wdata_o <= ret_mstatus;
                    cl_int_o       <= 1'b1;
                    cl_addr_o      <= mepc_i;
                    state          <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed literal scenarios plus randomized traffic checked
// every cycle against a schedule-based reference model.
module tb_int_ctrl;

    localparam int unsigned N = 4;
    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] MRET   = 32'h3020_0073;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          timer_int_i, soft_int_i;
    logic [N-1:0]  ext_irq_i;
    logic [31:0]   id_inst_i, id_pc_i, id_jump_pc_i, ex_branch_pc_i;
    logic          id_jump_flag_i, ex_branch_flag_i;
    logic [31:0]   mstatus_i, mie_i, mtvec_i, mepc_i;
    logic [11:0]   cl_csr_waddr_o;
    logic [31:0]   cl_csr_wdata_o, cl_addr_o, mip_o;
    logic          cl_csr_we_o, cl_int_o, cl_stall_o;
    logic [N-1:0]  ext_claim_o;

    always #5 clk = ~clk;

    int_ctrl #(.NUM_EXT_IRQ(N), .VECTORED_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .timer_int_i(timer_int_i), .soft_int_i(soft_int_i), .ext_irq_i(ext_irq_i),
        .id_inst_i(id_inst_i), .id_pc_i(id_pc_i),
        .id_jump_flag_i(id_jump_flag_i), .id_jump_pc_i(id_jump_pc_i),
        .ex_branch_flag_i(ex_branch_flag_i), .ex_branch_pc_i(ex_branch_pc_i),
        .mstatus_i(mstatus_i), .mie_i(mie_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
        .cl_csr_waddr_o(cl_csr_waddr_o), .cl_csr_wdata_o(cl_csr_wdata_o),
        .cl_csr_we_o(cl_csr_we_o), .cl_int_o(cl_int_o), .cl_addr_o(cl_addr_o),
        .cl_stall_o(cl_stall_o), .ext_claim_o(ext_claim_o), .mip_o(mip_o)
    );

    typedef struct packed {
        logic         we;
        logic [11:0]  waddr;
        logic [31:0]  wdata;
        logic         irq;
        logic [31:0]  addr;
        logic [N-1:0] claim;
    } out_t;

    out_t        slot [0:3];
    int unsigned remaining = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          chk_en = 1'b0;
    bit          have_mst = 1'b0;
    logic [31:0] last_mst;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic out_t mk(input logic we, input logic [11:0] a, input logic [31:0] d,
                                input logic irq, input logic [31:0] ad, input logic [N-1:0] cl);
        mk = {we, a, d, irq, ad, cl};
    endfunction

    function automatic logic [31:0] mip_model();
        mip_model = (32'(ext_irq_i) << 16) | (32'(soft_int_i) << 3) | (32'(timer_int_i) << 7);
    endfunction

    // kind: 0 none, 1 trap, 2 mret; claim == N means no external claim
    function automatic void decide(output int kind, output logic [31:0] cause,
                                   output logic [31:0] epc, output int unsigned claim);
        logic [31:0] pend;
        kind  = 0;
        cause = '0;
        epc   = '0;
        claim = N;
        pend  = mip_model() & mie_i;
        if ((id_inst_i == ECALL || id_inst_i == EBREAK) && !ex_branch_flag_i) begin
            kind  = 1;
            cause = (id_inst_i == ECALL) ? 32'd11 : 32'd3;
            epc   = id_pc_i;
        end else if (mstatus_i[3] && (pend[31:16] != 16'h0 || pend[3] || pend[7])) begin
            kind = 1;
            if (pend[31:16] != 16'h0) begin
                for (int b = 31; b >= 16; b--)
                    if (pend[b]) begin
                        cause = 32'h8000_0000 + 32'(b);
                        claim = 32'(b - 16);
                    end
            end else if (pend[3]) begin
                cause = 32'h8000_0003;
            end else begin
                cause = 32'h8000_0007;
            end
            epc = ex_branch_flag_i ? ex_branch_pc_i : (id_jump_flag_i ? id_jump_pc_i : id_pc_i);
        end else if (id_inst_i == MRET) begin
            kind = 2;
        end
    endfunction

    // Compare process: outputs sampled mid-cycle, then the model advances one edge.
    always @(negedge clk) begin
        int          kind;
        logic [31:0] cause, epc, base, hnd, mst;
        int unsigned cl;
        logic [N-1:0] oh;
        bit          busy_m;
        #2;
        busy_m = (remaining != 0);
        decide(kind, cause, epc, cl);
        if (busy_m) kind = 0;
        if (chk_en) begin
            check("we",    32'(cl_csr_we_o),    32'(slot[0].we));
            check("waddr", 32'(cl_csr_waddr_o), 32'(slot[0].waddr));
            check("wdata", cl_csr_wdata_o,      slot[0].wdata);
            check("int",   32'(cl_int_o),       32'(slot[0].irq));
            check("addr",  cl_addr_o,           slot[0].addr);
            check("claim", 32'(ext_claim_o),    32'(slot[0].claim));
            check("stall", 32'(cl_stall_o),     32'(busy_m || kind != 0));
            check("mip",   mip_o,               mip_model());
        end
        if (slot[0].we && slot[0].waddr == 12'h300) begin
            last_mst = slot[0].wdata;
            have_mst = 1'b1;
        end
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) slot[k] = '0;
            remaining = 0;
        end else begin
            for (int k = 0; k < 3; k++) slot[k] = slot[k+1];
            slot[3] = '0;
            if (remaining != 0) remaining--;
            if (kind == 1) begin
                base = {mtvec_i[31:2], 2'b00};
                hnd  = (mtvec_i[1:0] == 2'b01 && cause[31]) ? base + ((cause & 32'd31) << 2) : base;
                mst  = (mstatus_i & ~32'h1888) | 32'h1800 | (mstatus_i[3] ? 32'h80 : 32'h0);
                oh   = '0;
                if (cl < N) oh[cl] = 1'b1;
                slot[1] = mk(1'b1, 12'h341, epc,   1'b0, 32'h0, '0);
                slot[2] = mk(1'b1, 12'h342, cause, 1'b0, 32'h0, oh);
                slot[3] = mk(1'b1, 12'h300, mst,   1'b1, hnd,   '0);
                remaining = 4;
            end else if (kind == 2) begin
                mst = (mstatus_i & ~32'h88) | 32'h80 | (mstatus_i[7] ? 32'h8 : 32'h0);
                slot[1] = mk(1'b1, 12'h300, mst, 1'b1, mepc_i, '0);
                remaining = 2;
            end
        end
    end

    task automatic quiet();
        timer_int_i = 1'b0; soft_int_i = 1'b0; ext_irq_i = '0;
        id_inst_i = NOP; id_pc_i = 32'h0; id_jump_flag_i = 1'b0; id_jump_pc_i = 32'h0;
        ex_branch_flag_i = 1'b0; ex_branch_pc_i = 32'h0;
        mstatus_i = 32'h0; mie_i = 32'h0; mtvec_i = 32'h0; mepc_i = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge clk); quiet(); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1; #3;
        check("rst_we",    32'(cl_csr_we_o), 32'h0);
        check("rst_wdata", cl_csr_wdata_o,   32'h0);
        check("rst_int",   32'(cl_int_o),    32'h0);
        check("rst_addr",  cl_addr_o,        32'h0);
        check("rst_claim", 32'(ext_claim_o), 32'h0);
        check("rst_stall", 32'(cl_stall_o),  32'h0);
        have_mst = 1'b0;
    endtask

    task automatic cyc();
        @(negedge clk); #3;
    endtask

    initial begin
        quiet();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;

        // Timer interrupt, direct mode
        do_reset();
        @(negedge clk);
        mie_i = 32'h88; mstatus_i = 32'h8; timer_int_i = 1'b1; id_pc_i = 32'h100; mtvec_i = 32'h1000; #3;
        check("s1_c0_stall", 32'(cl_stall_o), 32'h1);
        cyc(); check("s1_c1_we", 32'(cl_csr_we_o), 32'h0); check("s1_c1_stall", 32'(cl_stall_o), 32'h1);
        cyc(); check("s1_c2_waddr", 32'(cl_csr_waddr_o), 32'h341); check("s1_c2_wdata", cl_csr_wdata_o, 32'h100);
        cyc(); check("s1_c3_wdata", cl_csr_wdata_o, 32'h8000_0007); check("s1_c3_stall", 32'(cl_stall_o), 32'h1);
        cyc(); check("s1_c4_wdata", cl_csr_wdata_o, 32'h1880); check("s1_c4_int", 32'(cl_int_o), 32'h1);
               check("s1_c4_addr", cl_addr_o, 32'h1000);
        @(negedge clk); mstatus_i = 32'h1880; #3;
        check("s1_c5_int", 32'(cl_int_o), 32'h0); check("s1_c5_stall", 32'(cl_stall_o), 32'h0);

        // External priority, vectored handler
        do_reset();
        @(negedge clk);
        ext_irq_i = 4'b0110; soft_int_i = 1'b1; mie_i = 32'h6_0008; mstatus_i = 32'h8;
        mtvec_i = 32'h2001; id_pc_i = 32'h180; #3;
        cyc(); cyc(); check("s2_c2_wdata", cl_csr_wdata_o, 32'h180);
        cyc(); check("s2_c3_cause", cl_csr_wdata_o, 32'h8000_0011); check("s2_c3_claim", 32'(ext_claim_o), 32'h2);
        cyc(); check("s2_c4_addr", cl_addr_o, 32'h2044); check("s2_c4_claim", 32'(ext_claim_o), 32'h0);

        // ECALL outranks a pending timer and is never vectored
        do_reset();
        @(negedge clk);
        id_inst_i = ECALL; id_pc_i = 32'h200; timer_int_i = 1'b1; mie_i = 32'h88; mstatus_i = 32'h8;
        mtvec_i = 32'h2001; #3;
        cyc(); id_inst_i = NOP;
        cyc(); check("s3_c2_wdata", cl_csr_wdata_o, 32'h200);
        cyc(); check("s3_c3_cause", cl_csr_wdata_o, 32'hB);
        cyc(); check("s3_c4_addr", cl_addr_o, 32'h2000); check("s3_c4_mst", cl_csr_wdata_o, 32'h1880);

        // Flushed ECALL does not trap; async epc follows the EX branch
        do_reset();
        @(negedge clk); id_inst_i = ECALL; ex_branch_flag_i = 1'b1; #3;
        check("s4_c0_stall", 32'(cl_stall_o), 32'h0);
        cyc(); check("s4_c1_stall", 32'(cl_stall_o), 32'h0); check("s4_c1_we", 32'(cl_csr_we_o), 32'h0);
        do_reset();
        @(negedge clk);
        timer_int_i = 1'b1; mie_i = 32'h88; mstatus_i = 32'h8; mtvec_i = 32'h1000;
        ex_branch_flag_i = 1'b1; ex_branch_pc_i = 32'h300; id_pc_i = 32'h400;
        id_jump_flag_i = 1'b1; id_jump_pc_i = 32'h500; #3;
        cyc(); cyc(); check("s4_c2_mepc", cl_csr_wdata_o, 32'h300);

        // MRET, then a held timer is retaken only once the redirect has gone
        do_reset();
        @(negedge clk);
        id_inst_i = MRET; mstatus_i = 32'h1880; mepc_i = 32'h104; timer_int_i = 1'b1;
        mie_i = 32'h88; mtvec_i = 32'h1000; #3;
        check("s5_c0_stall", 32'(cl_stall_o), 32'h1);
        @(negedge clk); id_inst_i = NOP; #3; check("s5_c1_we", 32'(cl_csr_we_o), 32'h0);
        cyc(); check("s5_c2_wdata", cl_csr_wdata_o, 32'h1888); check("s5_c2_int", 32'(cl_int_o), 32'h1);
               check("s5_c2_addr", cl_addr_o, 32'h104);
        @(negedge clk); mstatus_i = 32'h1888; #3;
        check("s5_c3_stall", 32'(cl_stall_o), 32'h1); check("s5_c3_we", 32'(cl_csr_we_o), 32'h0);
        cyc(); check("s5_c4_we", 32'(cl_csr_we_o), 32'h0);
        cyc(); check("s5_c5_waddr", 32'(cl_csr_waddr_o), 32'h341);

        // Reset in the middle of a trap sequence
        do_reset();
        @(negedge clk);
        timer_int_i = 1'b1; mie_i = 32'h88; mstatus_i = 32'h8; mtvec_i = 32'h1000; id_pc_i = 32'h120; #3;
        cyc();
        @(negedge clk); rst_n = 1'b0; #3; check("s6_c2_we", 32'(cl_csr_we_o), 32'h1);
        @(negedge clk); rst_n = 1'b1; timer_int_i = 1'b0; #3;
        check("s6_c3_we", 32'(cl_csr_we_o), 32'h0); check("s6_c3_stall", 32'(cl_stall_o), 32'h0);
        check("s6_c3_wdata", cl_csr_wdata_o, 32'h0);
        cyc(); check("s6_c4_we", 32'(cl_csr_we_o), 32'h0); check("s6_c4_int", 32'(cl_int_o), 32'h0);

        // Randomized traffic; CSRs only change while the controller is idle
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            int unsigned r;
            @(negedge clk);
            rst_n = ($urandom_range(0, 99) >= 2);
            r = $urandom_range(0, 99);
            id_inst_i = (r < 8) ? ECALL : (r < 12) ? EBREAK : (r < 20) ? MRET :
                        (r < 60) ? NOP : 32'($urandom);
            id_pc_i          = 32'($urandom) & ~32'h3;
            id_jump_flag_i   = ($urandom_range(0, 4) == 0);
            id_jump_pc_i     = 32'($urandom) & ~32'h3;
            ex_branch_flag_i = ($urandom_range(0, 5) == 0);
            ex_branch_pc_i   = 32'($urandom) & ~32'h3;
            timer_int_i      = ($urandom_range(0, 4) == 0);
            soft_int_i       = ($urandom_range(0, 5) == 0);
            ext_irq_i        = N'($urandom) & N'($urandom) & N'($urandom);
            if (remaining == 0) begin
                if (have_mst) begin
                    mstatus_i = last_mst;
                    have_mst  = 1'b0;
                end
                if ($urandom_range(0, 4) == 0) mstatus_i = 32'($urandom);
                if ($urandom_range(0, 4) == 0) mie_i     = 32'($urandom);
                if ($urandom_range(0, 4) == 0) mtvec_i   = 32'($urandom);
                if ($urandom_range(0, 4) == 0) mepc_i    = 32'($urandom) & ~32'h3;
            end
        end
        @(negedge clk); #3;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
